// File: rtl/rs_enc_parity_gen_pkg.sv
// Shared RS(32,28) constants and GF(256) helpers for the encoder/decoder pair.
package rs_enc_parity_gen_pkg;

    // GF(256) primitive polynomial x^8+x^4+x^3+x^2+1
    localparam logic [8:0] GF_POLY         = 9'h11D;
    localparam int         RS_PARITY_BYTES = 4;

    // g(x) = (x+1)(x+2)(x+4)(x+8) = x^4 + G3.x^3 + G2.x^2 + G1.x + G0
    localparam logic [7:0] G3 = 8'h0F;
    localparam logic [7:0] G2 = 8'h36;
    localparam logic [7:0] G1 = 8'h78;
    localparam logic [7:0] G0 = 8'h40;

    typedef enum logic {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } state_t;

    // GF(256) multiply; with one constant operand this folds to an XOR tree
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[7] ? ((x << 1) ^ GF_POLY[7:0]) : (x << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_enc_lfsr.sv
// Parity divider for the RS encoder: 4x8-bit LFSR dividing by g(x).
// step feeds a message byte in; shift drains parity out through p3.
import rs_enc_parity_gen_pkg::*;

module rs_enc_lfsr (
    input  logic       i_clk,
    input  logic       i_resb,
    input  logic       i_clear,
    input  logic       i_step,
    input  logic       i_shift,
    input  logic [7:0] i_data,
    output logic [7:0] o_p3,
    output logic [7:0] o_p2,
    output logic [7:0] o_p1,
    output logic [7:0] o_p0
);

    logic [7:0] fb;
    logic [7:0] fb_g3, fb_g2, fb_g1, fb_g0;

    assign fb    = i_data ^ o_p3;
    assign fb_g3 = gf_mul(fb, G3);
    assign fb_g2 = gf_mul(fb, G2);
    assign fb_g1 = gf_mul(fb, G1);
    assign fb_g0 = gf_mul(fb, G0);

    // Parity registers: clear beats step beats shift
    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            o_p3 <= '0;
            o_p2 <= '0;
            o_p1 <= '0;
            o_p0 <= '0;
        end else if (i_clear) begin
            o_p3 <= '0;
            o_p2 <= '0;
            o_p1 <= '0;
            o_p0 <= '0;
        end else if (i_step) begin
            o_p3 <= o_p2 ^ fb_g3;
            o_p2 <= o_p1 ^ fb_g2;
            o_p1 <= o_p0 ^ fb_g1;
            o_p0 <= fb_g0;
        end else if (i_shift) begin
            o_p3 <= o_p2;
            o_p2 <= o_p1;
            o_p1 <= o_p0;
            o_p0 <= '0;
        end
    end

endmodule

// File: rtl/rs_enc_parity_gen.sv
// Systematic RS(DATA_BYTES+4, DATA_BYTES) encoder: passes message bytes
// through a one-deep output slot, then appends p3..p0 from the LFSR.
import rs_enc_parity_gen_pkg::*;

module rs_enc_parity_gen #(
    parameter int DATA_BYTES = 28
) (
    input  logic       i_clk,
    input  logic       i_resb,
    input  logic       i_frame_sync,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_first,
    output logic       o_last
);

    localparam int              CNT_W     = 8;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_PAR  = CNT_W'(RS_PARITY_BYTES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              load_en, in_xfer, par_load;
    logic [7:0]        p3, p2, p1, p0;

    // Output slot can take a new byte when empty or being drained this cycle
    assign load_en  = !o_valid || i_ready;
    assign o_ready  = (state == S_DATA) && load_en && !i_frame_sync;
    assign in_xfer  = i_valid && o_ready;
    assign par_load = (state == S_PARITY) && load_en && !i_frame_sync;

    rs_enc_lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_resb  (i_resb),
        .i_clear (i_frame_sync),
        .i_step  (in_xfer),
        .i_shift (par_load),
        .i_data  (i_data),
        .o_p3    (p3),
        .o_p2    (p2),
        .o_p1    (p1),
        .o_p0    (p0)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) state <= S_DATA;
        else         state <= state_nxt;
    end

    // Next state: data phase until last message byte, parity phase for 4 loads
    always_comb begin
        state_nxt = state;
        if (i_frame_sync) begin
            state_nxt = S_DATA;
        end else begin
            case (state)
                S_DATA:   if (in_xfer && cnt == LAST_DATA) state_nxt = S_PARITY;
                S_PARITY: if (par_load && cnt == LAST_PAR) state_nxt = S_DATA;
                default:  state_nxt = S_DATA;
            endcase
        end
    end

    // Byte counter, reused for message and parity positions
    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            cnt <= '0;
        end else if (i_frame_sync) begin
            cnt <= '0;
        end else if (in_xfer) begin
            cnt <= (cnt == LAST_DATA) ? '0 : cnt + 1'b1;
        end else if (par_load) begin
            cnt <= (cnt == LAST_PAR) ? '0 : cnt + 1'b1;
        end
    end

    // Output slot: load message or parity, drop valid when drained empty-handed
    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end else if (i_frame_sync) begin
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end else if (in_xfer) begin
            o_data  <= i_data;
            o_valid <= 1'b1;
            o_first <= (cnt == '0);
            o_last  <= 1'b0;
        end else if (par_load) begin
            o_data  <= p3;
            o_valid <= 1'b1;
            o_first <= 1'b0;
            o_last  <= (cnt == LAST_PAR);
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_enc_parity_gen.sv
// Directed bench for rs_enc_parity_gen (DATA_BYTES=28): hand-computed parity
// vectors, backpressure, frame sync abort and async reset mid-parity.
module tb_rs_enc_parity_gen;

    logic       i_clk = 1'b0;
    logic       i_resb, i_frame_sync, i_valid, i_ready;
    logic [7:0] i_data;
    logic       o_ready, o_valid, o_first, o_last;
    logic [7:0] o_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg  [0:27];
    logic [7:0] expv [0:31];

    always #5 i_clk = ~i_clk;

    rs_enc_parity_gen #(.DATA_BYTES(28)) dut (
        .i_clk        (i_clk),
        .i_resb       (i_resb),
        .i_frame_sync (i_frame_sync),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_first      (o_first),
        .o_last       (o_last)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Message is zero except the last two bytes; parity given by hand
    task automatic set_cw(input logic [7:0] b26, input logic [7:0] b27,
                          input logic [7:0] q3, input logic [7:0] q2,
                          input logic [7:0] q1, input logic [7:0] q0);
        for (int k = 0; k < 28; k++) msg[k] = 8'h00;
        msg[26] = b26;
        msg[27] = b27;
        for (int k = 0; k < 28; k++) expv[k] = msg[k];
        expv[28] = q3; expv[29] = q2; expv[30] = q1; expv[31] = q0;
    endtask

    // Stream one codeword in and check all 32 output bytes; bp randomises handshakes
    task automatic run_cw(input string tag, input bit bp);
        int idx = 0, oidx = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
        bit acc = 1'b0, stall = 1'b0;
        logic [7:0] sd;
        logic sf, sl;
        sd = '0; sf = 1'b0; sl = 1'b0;
        while (oidx < 32 && cyc < 1000) begin
            @(negedge i_clk);
            cyc++;
            i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (acc) i_valid = 1'b0;
            acc = 1'b0;
            if (!i_valid && idx < 28 && (!bp || $urandom_range(0, 3) != 0)) begin
                i_valid = 1'b1;
                i_data  = msg[idx];
            end
            #1;
            if (stall) begin
                chk({tag, " hold_valid"}, {7'd0, o_valid}, 8'd1);
                chk({tag, " hold_data"},  o_data, sd);
                chk({tag, " hold_first"}, {7'd0, o_first}, {7'd0, sf});
                chk({tag, " hold_last"},  {7'd0, o_last},  {7'd0, sl});
            end
            stall = o_valid && !i_ready;
            sd = o_data; sf = o_first; sl = o_last;
            if (o_valid && i_ready) begin
                chk({tag, " data"},  o_data, expv[oidx]);
                chk({tag, " first"}, {7'd0, o_first}, {7'd0, oidx == 0});
                chk({tag, " last"},  {7'd0, o_last},  {7'd0, oidx == 31});
                if (oidx == 0)  first_cyc = cyc;
                if (oidx == 31) last_cyc  = cyc;
                oidx++;
            end
            if (i_valid && o_ready) begin
                acc = 1'b1;
                idx++;
            end
        end
        if (oidx < 32) chk({tag, " timeout_bytes"}, 8'(oidx), 8'd32);
        if (!bp) chk({tag, " span"}, 8'(last_cyc - first_cyc), 8'd31);
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_resb = 1'b0; i_frame_sync = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_data = 8'h00;
        #12;
        chk("rst o_valid", {7'd0, o_valid}, 8'd0);
        chk("rst o_data",  o_data, 8'h00);
        chk("rst o_first", {7'd0, o_first}, 8'd0);
        chk("rst o_last",  {7'd0, o_last},  8'd0);
        chk("rst o_ready", {7'd0, o_ready}, 8'd1);
        @(negedge i_clk);
        i_resb = 1'b1;

        // All-zero message
        set_cw(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_cw("zero", 1'b0);
        // Last byte 1 -> parity equals generator coefficients
        set_cw(8'h00, 8'h01, 8'h0F, 8'h36, 8'h78, 8'h40);
        run_cw("unit", 1'b0);
        // Last byte 2 -> 2*g, under random backpressure
        set_cw(8'h00, 8'h02, 8'h1E, 8'h6C, 8'hF0, 8'h80);
        run_cw("two_bp", 1'b1);
        // 0x01,0x0F -> feedback cancels on last step, pure shift of g
        set_cw(8'h01, 8'h0F, 8'h36, 8'h78, 8'h40, 8'h00);
        run_cw("cancel_bp", 1'b1);
        // Last byte 3 -> g ^ 2g
        set_cw(8'h00, 8'h03, 8'h11, 8'h5A, 8'h88, 8'hC0);
        run_cw("three", 1'b0);

        // Frame sync after 10 nonzero data bytes
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_data  = 8'(8'hA5 + k);
        end
        @(negedge i_clk);
        i_frame_sync = 1'b1;
        i_data       = 8'h77;
        #1;
        chk("sync o_ready", {7'd0, o_ready}, 8'd0);
        @(negedge i_clk);
        i_frame_sync = 1'b0;
        i_valid      = 1'b0;
        #1;
        chk("sync o_valid", {7'd0, o_valid}, 8'd0);
        chk("sync o_first", {7'd0, o_first}, 8'd0);
        set_cw(8'h00, 8'h01, 8'h0F, 8'h36, 8'h78, 8'h40);
        run_cw("after_sync", 1'b0);

        // Async reset while parity byte p2 is on the output
        for (int k = 0; k < 28; k++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_data  = 8'h3C ^ 8'(k);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        chk("pre_rst o_valid", {7'd0, o_valid}, 8'd1);
        #1;
        i_resb = 1'b0;
        #1;
        chk("mid_rst o_valid", {7'd0, o_valid}, 8'd0);
        chk("mid_rst o_data",  o_data, 8'h00);
        chk("mid_rst o_last",  {7'd0, o_last}, 8'd0);
        chk("mid_rst o_ready", {7'd0, o_ready}, 8'd1);
        @(negedge i_clk);
        i_resb = 1'b1;
        set_cw(8'h00, 8'h02, 8'h1E, 8'h6C, 8'hF0, 8'h80);
        run_cw("after_rst", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
